// File: rtl/fetch_buffered.sv
// Fetch stage: PC + one-cycle-latency imem requests feeding a DEPTH-entry {pc,instr} prefetch FIFO; data valid 2 cycles after issue.
// Issue stalls while count+inflight fills the FIFO; redirect reloads PC, flushes FIFO and drops the in-flight response.
module fetch_buffered #(
   parameter int              N        = 64,
   parameter int              INC      = 4,
   parameter logic [N-1:0]    RESET_PC = '0,
   parameter int              DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     PCSrc_F,
   input  logic [N-1:0]             PCBranch_F,
   output logic                     imem_req_F,
   output logic [N-1:0]             imem_addr_F,
   input  logic [31:0]              imem_data_F,
   output logic                     instr_valid_D,
   input  logic                     instr_ready_D,
   output logic [31:0]              instr_D,
   output logic [N-1:0]             pc_D,
   output logic [$clog2(DEPTH):0]   count_F
);
   localparam int             PW      = $clog2(DEPTH);
   localparam logic [N-1:0]   INC_W   = N'(INC);
   localparam logic [PW+1:0]  DEPTH_W = (PW+2)'(DEPTH);

   logic [N-1:0]  pc_q, pc_d;
   logic          inflight_q;
   logic [N-1:0]  inflight_pc_q;
   logic          squash_q;
   logic [N-1:0]  fifo_pc_q    [DEPTH];
   logic [31:0]   fifo_instr_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [PW:0]   count_q, count_d;
   logic [PW+1:0] reserved;
   logic          issue, push, pop;

   // A slot is reserved for the outstanding response, so a push never meets a full FIFO.
   always_comb begin
      reserved = {1'b0, count_q} + {{(PW+1){1'b0}}, inflight_q};
      issue    = !reset && !PCSrc_F && (reserved < DEPTH_W);
      push     = !reset && !PCSrc_F && inflight_q && !squash_q;
      pop      = !reset && !PCSrc_F && (count_q != '0) && instr_ready_D;
   end

   always_comb begin
      pc_d = pc_q;
      if (PCSrc_F)
         pc_d = PCBranch_F;
      else if (issue)
         pc_d = pc_q + INC_W;
   end

   always_comb begin
      count_d = count_q;
      if (PCSrc_F)
         count_d = '0;
      else if (push && !pop)
         count_d = count_q + (PW+1)'(1);
      else if (!push && pop)
         count_d = count_q - (PW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= RESET_PC;
         squash_q      <= 1'b1;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= issue;
         inflight_pc_q <= pc_q;
         squash_q      <= 1'b0;
         count_q       <= count_d;
         if (PCSrc_F) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push)
               wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
               rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
         fifo_instr_q[wr_ptr_q] <= imem_data_F;
      end
   end

   always_comb begin
      imem_req_F    = issue;
      imem_addr_F   = reset ? RESET_PC : pc_q;
      instr_valid_D = !reset && (count_q != '0);
      count_F       = reset ? '0 : count_q;
      instr_D       = fifo_instr_q[rd_ptr_q];
      pc_D          = fifo_pc_q[rd_ptr_q];
   end
endmodule

// File: tb/tb_fetch_buffered.sv
// Directed bench for fetch_buffered: reset, streaming, backpressure, redirects, PC wrap and mid-run reset.
module tb_fetch_buffered;
   localparam logic [63:0] RP2  = 64'hFFFF_FFFF_FFFF_FFF8;
   localparam logic [31:0] MASK = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset, pcsrc, ready;
   logic [63:0] pcbranch;

   logic        req1, valid1, req2, valid2;
   logic [63:0] addr1, pc1, addr2, pc2;
   logic [31:0] data1, instr1, data2, instr2;
   logic [2:0]  cnt1, cnt2;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_buffered #(.N(64), .INC(4), .RESET_PC(64'd0), .DEPTH(4)) dut1 (
      .clk(clk), .reset(reset), .PCSrc_F(pcsrc), .PCBranch_F(pcbranch),
      .imem_req_F(req1), .imem_addr_F(addr1), .imem_data_F(data1),
      .instr_valid_D(valid1), .instr_ready_D(ready), .instr_D(instr1),
      .pc_D(pc1), .count_F(cnt1)
   );

   fetch_buffered #(.N(64), .INC(4), .RESET_PC(RP2), .DEPTH(4)) dut2 (
      .clk(clk), .reset(reset), .PCSrc_F(pcsrc), .PCBranch_F(pcbranch),
      .imem_req_F(req2), .imem_addr_F(addr2), .imem_data_F(data2),
      .instr_valid_D(valid2), .instr_ready_D(ready), .instr_D(instr2),
      .pc_D(pc2), .count_F(cnt2)
   );

   always #5 clk = ~clk;

   // One-cycle-latency instruction memory: data = addr ^ MASK.
   always @(posedge clk) begin
      data1 <= addr1[31:0] ^ MASK;
      data2 <= addr2[31:0] ^ MASK;
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mem(input logic [63:0] a);
      logic [31:0] lo;
      lo = a[31:0];
      return {32'd0, lo ^ MASK};
   endfunction

   initial begin
      reset = 1'b1; pcsrc = 1'b0; pcbranch = 64'd0; ready = 1'b1;

      // Reset held for three sampled edges
      for (int i = 0; i < 2; i++) begin
         nxt(); #1;
         chk("rst_req",  64'(req1),   64'd0);
         chk("rst_vld",  64'(valid1), 64'd0);
         chk("rst_addr", addr1,       64'd0);
         chk("rst_cnt",  64'(cnt1),   64'd0);
      end
      nxt(); reset = 1'b0; #1;
      chk("c0_req",  64'(req1),   64'd1);
      chk("c0_addr", addr1,       64'd0);
      chk("c0_vld",  64'(valid1), 64'd0);
      nxt(); #1;
      chk("c1_req",  64'(req1),   64'd1);
      chk("c1_addr", addr1,       64'd4);
      chk("c1_vld",  64'(valid1), 64'd0);

      // Streaming with ready held high
      for (int i = 0; i < 10; i++) begin
         nxt(); #1;
         chk("str_vld",   64'(valid1), 64'd1);
         chk("str_pc",    pc1,         64'(4 * i));
         chk("str_instr", 64'(instr1), mem(64'(4 * i)));
         chk("str_cnt",   64'(cnt1),   64'd1);
         chk("str_addr",  addr1,       64'(4 * (i + 2)));
      end

      // Mid-run reset, then backpressure from release
      nxt(); reset = 1'b1; ready = 1'b0; #1;
      chk("mrst_vld", 64'(valid1), 64'd0);
      chk("mrst_req", 64'(req1),   64'd0);
      nxt(); reset = 1'b0; #1;
      chk("bp0_cnt",  64'(cnt1),   64'd0);
      chk("bp0_vld",  64'(valid1), 64'd0);
      chk("bp0_addr", addr1,       64'd0);
      chk("bp0_req",  64'(req1),   64'd1);
      for (int i = 1; i < 8; i++) begin
         nxt(); #1;
         chk("bp_req", 64'(req1), (i <= 3) ? 64'd1 : 64'd0);
         chk("bp_cnt", 64'(cnt1), (i <= 1) ? 64'd0 : ((i >= 5) ? 64'd4 : 64'(i - 1)));
      end
      chk("bp_headpc", pc1, 64'd0);
      nxt(); ready = 1'b1; #1;
      chk("bp8_req", 64'(req1), 64'd0);
      chk("bp8_pc",  pc1,       64'd0);
      for (int j = 1; j <= 4; j++) begin
         nxt(); #1;
         chk("bpd_vld", 64'(valid1), 64'd1);
         chk("bpd_pc",  pc1,         64'(4 * j));
         if (j == 1) begin
            chk("bp_resume_req",  64'(req1), 64'd1);
            chk("bp_resume_addr", addr1,     64'd16);
         end
      end

      // Redirect while full
      nxt(); reset = 1'b1; ready = 1'b0;
      nxt(); reset = 1'b0;
      for (int i = 1; i <= 5; i++) nxt();
      #1;
      chk("full_cnt", 64'(cnt1), 64'd4);
      chk("full_req", 64'(req1), 64'd0);
      nxt(); pcsrc = 1'b1; pcbranch = 64'h1000; #1;
      chk("rd_r_req", 64'(req1), 64'd0);
      nxt(); pcsrc = 1'b0; ready = 1'b1; #1;
      chk("rd_r1_cnt",  64'(cnt1),   64'd0);
      chk("rd_r1_vld",  64'(valid1), 64'd0);
      chk("rd_r1_req",  64'(req1),   64'd1);
      chk("rd_r1_addr", addr1,       64'h1000);
      nxt(); #1;
      chk("rd_r2_vld",  64'(valid1), 64'd0);
      chk("rd_r2_addr", addr1,       64'h1004);
      nxt(); #1;
      chk("rd_r3_vld",   64'(valid1), 64'd1);
      chk("rd_r3_pc",    pc1,         64'h1000);
      chk("rd_r3_instr", 64'(instr1), mem(64'h1000));
      nxt(); #1;
      chk("rd_r4_pc",    pc1,         64'h1004);

      // Redirect with a response in flight, then a second redirect
      nxt(); reset = 1'b1;
      nxt(); reset = 1'b0;
      for (int i = 1; i <= 8; i++) nxt();
      #1;
      chk("if_addr20", addr1, 64'h20);
      nxt(); pcsrc = 1'b1; pcbranch = 64'h100; #1;
      chk("if_r_req", 64'(req1), 64'd0);
      nxt(); pcbranch = 64'h200; #1;
      chk("if_r2_req", 64'(req1),   64'd0);
      chk("if_r2_cnt", 64'(cnt1),   64'd0);
      chk("if_r2_vld", 64'(valid1), 64'd0);
      nxt(); pcsrc = 1'b0; #1;
      chk("if_t1_req",  64'(req1),   64'd1);
      chk("if_t1_addr", addr1,       64'h200);
      chk("if_t1_vld",  64'(valid1), 64'd0);
      nxt(); #1;
      chk("if_t2_vld",  64'(valid1), 64'd0);
      nxt(); #1;
      chk("if_t3_vld",   64'(valid1), 64'd1);
      chk("if_t3_pc",    pc1,         64'h200);
      chk("if_t3_instr", 64'(instr1), mem(64'h200));
      nxt(); #1;
      chk("if_t4_pc",    pc1,         64'h204);

      // PC wrap on the second instance, then mid-stream reset
      nxt(); reset = 1'b1;
      nxt(); reset = 1'b0; #1;
      chk("wr0_addr", addr2,       RP2);
      chk("wr0_req",  64'(req2),   64'd1);
      chk("wr0_vld",  64'(valid2), 64'd0);
      nxt(); #1;
      chk("wr1_addr", addr2, 64'hFFFF_FFFF_FFFF_FFFC);
      nxt(); #1;
      chk("wr2_addr",  addr2,       64'd0);
      chk("wr2_pc",    pc2,         RP2);
      chk("wr2_instr", 64'(instr2), mem(RP2));
      nxt(); #1;
      chk("wr3_pc",    pc2,         64'hFFFF_FFFF_FFFF_FFFC);
      nxt(); #1;
      chk("wr4_pc",    pc2,         64'd0);
      chk("wr4_instr", 64'(instr2), 64'h0000_0000_A5A5_0000);
      nxt(); reset = 1'b1; #1;
      chk("wrr_vld", 64'(valid2), 64'd0);
      chk("wrr_req", 64'(req2),   64'd0);
      nxt(); reset = 1'b0; #1;
      chk("wrr1_cnt",  64'(cnt2),   64'd0);
      chk("wrr1_vld",  64'(valid2), 64'd0);
      chk("wrr1_addr", addr2,       RP2);
      nxt(); nxt(); #1;
      chk("wrr3_vld", 64'(valid2), 64'd1);
      chk("wrr3_pc",  pc2,         RP2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
